// File: rtl/load_store_unit.sv
// load_store_unit: data-memory initiator for the core pipeline.
// Handles byte/half/word loads and stores against a word-aligned memory that
// has a combinational read and writes on posedge clk. Loads are sign- or
// zero-extended. Sub-word stores use read-modify-write.
// Optional feature macro: LSU_MISALIGNED_EN. When it is defined, accesses that
// cross a word boundary are split into two words. When it is undefined, any
// naturally misaligned access is rejected with resp_err.
module load_store_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

`ifdef LSU_MISALIGNED_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, RD0, WR0, RD1, WR1, RESP} state_t;

    state_t            state_reg, state_next;
    logic              write_reg, unsigned_reg;
    logic [1:0]        size_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg, word0_reg, word0_next;
    logic              resp_valid_next, resp_err_next, mem_write_next;
    logic [DATA_W-1:0] resp_rdata_next, mem_wd_next;
    logic [ADDR_W-1:0] mem_adr_next;

    // The request being worked on: live inputs while idle, latched copy afterwards.
    logic              is_idle, cur_write, cur_unsigned;
    logic [1:0]        cur_size, off;
    logic [ADDR_W-1:0] cur_addr, word_a, word_b;
    logic [DATA_W-1:0] cur_wdata;
    logic [3:0]        base_mask;
    logic [2:0]        nbytes;
    logic              crossing, natural_mis, req_err;
    logic [4:0]        shamt;
    logic [2*DATA_W-1:0] wdata_wide;
    logic [7:0]        lane_mask;
    logic              hi_sel;
    logic [DATA_W-1:0] merge_word, ld_lo, ld_word, ld_ext;

    assign is_idle      = (state_reg == IDLE);
    assign req_ready    = is_idle;
    assign cur_write    = is_idle ? req_write    : write_reg;
    assign cur_unsigned = is_idle ? req_unsigned : unsigned_reg;
    assign cur_size     = is_idle ? req_size     : size_reg;
    assign cur_addr     = is_idle ? req_addr     : addr_reg;
    assign cur_wdata    = is_idle ? req_wdata    : wdata_reg;

    assign off    = cur_addr[1:0];
    assign word_a = {cur_addr[ADDR_W-1:2], 2'b00};
    assign word_b = word_a + ADDR_W'(4);   // wraps 0xFFFFFFFC -> 0
    assign shamt  = {off, 3'b000};

    // Lane pattern and byte count for the access size.
    always_comb begin
        base_mask = 4'b1111;
        nbytes    = 3'd4;
        case (cur_size)
            2'b00:   begin base_mask = 4'b0001; nbytes = 3'd1; end
            2'b01:   begin base_mask = 4'b0011; nbytes = 3'd2; end
            default: begin base_mask = 4'b1111; nbytes = 3'd4; end
        endcase
    end

    assign crossing    = ({1'b0, off} + nbytes) > 3'd4;
    assign natural_mis = ((cur_size == 2'b01) && off[0]) ||
                         ((cur_size == 2'b10) && (off != 2'b00));
    assign req_err     = (cur_size == 2'b11) || (!MIS_EN && natural_mis);

    // Store data and lane enables spread over the two words an access may touch.
    assign wdata_wide = {{DATA_W{1'b0}}, cur_wdata} << shamt;
    assign lane_mask  = {4'b0000, base_mask} << off;
    assign hi_sel     = (state_reg == RD1);

    // Replace the target lanes of the word just read with store data.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign merge_word[8*gi +: 8] =
                (hi_sel ? lane_mask[gi+4] : lane_mask[gi])
                    ? (hi_sel ? wdata_wide[DATA_W + 8*gi +: 8] : wdata_wide[8*gi +: 8])
                    : mem_rdata[8*gi +: 8];
        end
    endgenerate

    // Load: low word is live in RD0, otherwise the one captured in RD0.
    assign ld_lo   = (state_reg == RD0) ? mem_rdata : word0_reg;
    assign ld_word = DATA_W'({mem_rdata, ld_lo} >> shamt);

    // Sign or zero extension of the load result.
    always_comb begin
        ld_ext = ld_word;
        case (cur_size)
            2'b00:   ld_ext = cur_unsigned ? {24'h0, ld_word[7:0]}
                                           : {{24{ld_word[7]}}, ld_word[7:0]};
            2'b01:   ld_ext = cur_unsigned ? {16'h0, ld_word[15:0]}
                                           : {{16{ld_word[15]}}, ld_word[15:0]};
            default: ld_ext = ld_word;
        endcase
    end

    // Next state plus next values of the registered memory/response outputs.
    always_comb begin
        state_next      = state_reg;
        word0_next      = word0_reg;
        resp_valid_next = 1'b0;
        resp_err_next   = 1'b0;
        resp_rdata_next = '0;
        mem_adr_next    = '0;
        mem_wd_next     = '0;
        mem_write_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (req_err) begin
                        state_next      = RESP;
                        resp_valid_next = 1'b1;
                        resp_err_next   = 1'b1;
                    end else if (cur_write && (cur_size == 2'b10) && (off == 2'b00)) begin
                        state_next     = WR0;
                        mem_adr_next   = word_a;
                        mem_wd_next    = merge_word;
                        mem_write_next = 1'b1;
                    end else begin
                        state_next   = RD0;
                        mem_adr_next = word_a;
                    end
                end
            end
            RD0: begin
                word0_next = mem_rdata;
                if (cur_write) begin
                    state_next     = WR0;
                    mem_adr_next   = word_a;
                    mem_wd_next    = merge_word;
                    mem_write_next = 1'b1;
                end else if (crossing) begin
                    state_next   = RD1;
                    mem_adr_next = word_b;
                end else begin
                    state_next      = RESP;
                    resp_valid_next = 1'b1;
                    resp_rdata_next = ld_ext;
                end
            end
            WR0: begin
                if (crossing) begin
                    state_next   = RD1;
                    mem_adr_next = word_b;
                end else begin
                    state_next      = RESP;
                    resp_valid_next = 1'b1;
                end
            end
            RD1: begin
                if (cur_write) begin
                    state_next     = WR1;
                    mem_adr_next   = word_b;
                    mem_wd_next    = merge_word;
                    mem_write_next = 1'b1;
                end else begin
                    state_next      = RESP;
                    resp_valid_next = 1'b1;
                    resp_rdata_next = ld_ext;
                end
            end
            WR1: begin
                state_next      = RESP;
                resp_valid_next = 1'b1;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, latched request and registered outputs; reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            write_reg    <= 1'b0;
            unsigned_reg <= 1'b0;
            size_reg     <= 2'b00;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            word0_reg    <= '0;
            resp_valid   <= 1'b0;
            resp_err     <= 1'b0;
            resp_rdata   <= '0;
            mem_adr      <= '0;
            mem_wd       <= '0;
            mem_write    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            word0_reg  <= word0_next;
            resp_valid <= resp_valid_next;
            resp_err   <= resp_err_next;
            resp_rdata <= resp_rdata_next;
            mem_adr    <= mem_adr_next;
            mem_wd     <= mem_wd_next;
            mem_write  <= mem_write_next;
            if (is_idle && req_valid) begin
                write_reg    <= req_write;
                unsigned_reg <= req_unsigned;
                size_reg     <= req_size;
                addr_reg     <= req_addr;
                wdata_reg    <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven self-checking bench for load_store_unit.
// A bench-owned word memory serves the DUT; expected responses go into a
// scoreboard queue at request time and are checked when resp_valid pulses.
// Build with LSU_MISALIGNED_EN defined to exercise the split-access vectors.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, mem_write;
    logic [31:0] resp_rdata, mem_adr, mem_wd, mem_rdata;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_adr      (mem_adr),
        .mem_wd       (mem_wd),
        .mem_write    (mem_write),
        .mem_rdata    (mem_rdata)
    );

    // Word memory: combinational read, write on posedge; preloaded first.
    logic [31:0] mem [0:1023];
    assign mem_rdata = mem[mem_adr[11:2]];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[250]  = 32'h88776655;   // 0x3E8
        mem[251]  = 32'h44332211;   // 0x3EC
        mem[1023] = 32'hA1B2C3D4;   // 0xFFFFFFFC
        mem[0]    = 32'h01020304;   // 0x00000000
        forever begin
            @(posedge clk);
            if (mem_write) mem[mem_adr[11:2]] <= mem_wd;
        end
    end

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_wr;
        logic        chk_wd;
        logic [31:0] exp_wd;
    } vec_t;

    typedef struct {
        vec_t v;
        int   acc;
        int   wr_base;
    } sb_t;

    vec_t vecs[$];
    sb_t  sbq[$];
    int   asserts = 0;
    int   fails   = 0;
    int   cyc     = 0;
    int   wr_count = 0;
    int   ntx     = 0;
    logic [31:0] last_wd = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err,
                                input int lat, input int nwr, input logic chk_wd,
                                input logic [31:0] exp_wd);
        vec_t v;
        v.w = w; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = lat;
        v.exp_wr = nwr; v.chk_wd = chk_wd; v.exp_wd = exp_wd;
        return v;
    endfunction

    // Response monitor: count write strobes, pop and compare on resp_valid.
    always @(negedge clk) begin
        sb_t e;
        int  lat;
        if (mem_write) begin
            wr_count++;
            last_wd = mem_wd;
        end
        if (resp_valid) begin
            if (sbq.size() == 0) begin
                asserts++;
                fails++;
                $display("FAIL unexpected_resp: got rdata=%h err=%b, required no response",
                         resp_rdata, resp_err);
            end else begin
                e   = sbq.pop_front();
                lat = cyc - e.acc + 1;
                ntx++;
                $display("txn %0d: %s size=%0d uns=%b addr=%h wdata=%h -> rdata=%h err=%b lat=%0d writes=%0d",
                         ntx, e.v.w ? "st" : "ld", e.v.sz, e.v.uns, e.v.addr, e.v.wdata,
                         resp_rdata, resp_err, lat, wr_count - e.wr_base);
                chk("rdata",   resp_rdata, e.v.exp_rdata);
                chk("err",     {31'b0, resp_err}, {31'b0, e.v.exp_err});
                chk("latency", lat, e.v.exp_lat);
                chk("writes",  wr_count - e.wr_base, e.v.exp_wr);
                if (e.v.chk_wd) chk("mem_wd", last_wd, e.v.exp_wd);
            end
        end
    end

    // Present one request, wait (bounded) for acceptance, queue its expectation.
    task automatic send(input vec_t v);
        sb_t e;
        bit  done;
        done = 1'b0;
        @(negedge clk);
        req_valid    = 1'b1;
        req_write    = v.w;
        req_size     = v.sz;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        for (int i = 0; i < 20 && !done; i++) begin
            if (req_ready) begin
                e.v = v;
                e.acc = cyc + 1;
                e.wr_base = wr_count;
                sbq.push_back(e);
                @(posedge clk);
                #1;
                req_valid = 1'b0;
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            asserts++;
            fails++;
            $display("FAIL req_ready_timeout: got ready=0 for 20 cycles, required 1 (addr %h)", v.addr);
            req_valid = 1'b0;
        end
    endtask

    initial begin
        int snap;
        rst_n = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready",  {31'b0, req_ready},  32'h1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_resp_err",   {31'b0, resp_err},   32'h0);
        chk("rst_resp_rdata", resp_rdata,          32'h0);
        chk("rst_mem_adr",    mem_adr,             32'h0);
        chk("rst_mem_wd",     mem_wd,              32'h0);
        chk("rst_mem_write",  {31'b0, mem_write},  32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of a sub-word store's read phase.
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h3ED; req_wdata = 32'h99;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("midrst_rd0_adr", mem_adr, 32'h3EC);
        @(negedge clk);
        snap = wr_count;
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_adr",    mem_adr,             32'h0);
        chk("midrst_mem_wd",     mem_wd,              32'h0);
        chk("midrst_mem_write",  {31'b0, mem_write},  32'h0);
        chk("midrst_resp_valid", {31'b0, resp_valid}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready",  {31'b0, req_ready}, 32'h1);
        chk("midrst_writes", wr_count - snap,    32'h0);
        chk("midrst_mem",    mem[251],           32'h44332211);

        // w, size, uns, addr, wdata, exp_rdata, exp_err, latency, writes, chk_wd, exp_wd
        vecs.push_back(mk(0, 2'b10, 0, 32'h3E8, 0, 32'h88776655, 0, 2, 0, 0, 0));
        vecs.push_back(mk(0, 2'b00, 0, 32'h3EB, 0, 32'hFFFFFF88, 0, 2, 0, 0, 0));
        vecs.push_back(mk(0, 2'b00, 1, 32'h3EB, 0, 32'h00000088, 0, 2, 0, 0, 0));
        vecs.push_back(mk(0, 2'b01, 0, 32'h3EA, 0, 32'hFFFF8877, 0, 2, 0, 0, 0));
        vecs.push_back(mk(0, 2'b01, 1, 32'h3EA, 0, 32'h00008877, 0, 2, 0, 0, 0));
        vecs.push_back(mk(0, 2'b00, 0, 32'h3E8, 0, 32'h00000055, 0, 2, 0, 0, 0));
        vecs.push_back(mk(0, 2'b01, 0, 32'h3EC, 0, 32'h00002211, 0, 2, 0, 0, 0));
        vecs.push_back(mk(0, 2'b00, 0, 32'h3EF, 0, 32'h00000044, 0, 2, 0, 0, 0));
        vecs.push_back(mk(0, 2'b11, 0, 32'h3E8, 0, 32'h0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 2'b11, 0, 32'h3E8, 32'hFFFFFFFF, 32'h0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 2'b10, 0, 32'h3E8, 0, 32'h88776655, 0, 2, 0, 0, 0));
`ifdef LSU_MISALIGNED_EN
        vecs.push_back(mk(0, 2'b10, 0, 32'h3EA, 0, 32'h22118877, 0, 3, 0, 0, 0));
        vecs.push_back(mk(0, 2'b01, 0, 32'h3E9, 0, 32'h00007766, 0, 2, 0, 0, 0));
        vecs.push_back(mk(0, 2'b01, 1, 32'h3EB, 0, 32'h00001188, 0, 3, 0, 0, 0));
`else
        vecs.push_back(mk(0, 2'b10, 0, 32'h3EA, 0, 32'h0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 2'b01, 0, 32'h3E9, 0, 32'h0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 2'b01, 0, 32'h3EB, 32'hBEEF, 32'h0, 1, 1, 0, 0, 0));
`endif
        vecs.push_back(mk(1, 2'b00, 0, 32'h3E9, 32'hAB, 32'h0, 0, 3, 1, 1, 32'h8877AB55));
        vecs.push_back(mk(0, 2'b10, 0, 32'h3E8, 0, 32'h8877AB55, 0, 2, 0, 0, 0));
        vecs.push_back(mk(1, 2'b01, 0, 32'h3EE, 32'hCAFE, 32'h0, 0, 3, 1, 1, 32'hCAFE2211));
        vecs.push_back(mk(0, 2'b10, 0, 32'h3EC, 0, 32'hCAFE2211, 0, 2, 0, 0, 0));
        vecs.push_back(mk(1, 2'b10, 0, 32'h3EC, 32'h12345678, 32'h0, 0, 2, 1, 1, 32'h12345678));
        vecs.push_back(mk(0, 2'b10, 0, 32'h3EC, 0, 32'h12345678, 0, 2, 0, 0, 0));
        vecs.push_back(mk(0, 2'b00, 1, 32'h3EF, 0, 32'h00000012, 0, 2, 0, 0, 0));
`ifdef LSU_MISALIGNED_EN
        vecs.push_back(mk(1, 2'b10, 0, 32'h3E8, 32'h88776655, 32'h0, 0, 2, 1, 1, 32'h88776655));
        vecs.push_back(mk(1, 2'b10, 0, 32'h3EC, 32'h44332211, 32'h0, 0, 2, 1, 1, 32'h44332211));
        vecs.push_back(mk(1, 2'b10, 0, 32'h3EB, 32'hDEADBEEF, 32'h0, 0, 5, 2, 1, 32'h44DEADBE));
        vecs.push_back(mk(0, 2'b10, 0, 32'h3E8, 0, 32'hEF776655, 0, 2, 0, 0, 0));
        vecs.push_back(mk(0, 2'b10, 0, 32'h3EC, 0, 32'h44DEADBE, 0, 2, 0, 0, 0));
        vecs.push_back(mk(0, 2'b10, 0, 32'hFFFFFFFE, 0, 32'h0304A1B2, 0, 3, 0, 0, 0));
`endif

        // Requests go out back-to-back: each waits only for req_ready.
        foreach (vecs[i]) send(vecs[i]);

        for (int i = 0; i < 50 && sbq.size() != 0; i++) @(negedge clk);
        if (sbq.size() != 0) begin
            asserts++;
            fails++;
            $display("FAIL resp_timeout: got %0d responses outstanding, required 0", sbq.size());
        end

`ifdef LSU_MISALIGNED_EN
        chk("final_mem_3e8", mem[250], 32'hEF776655);
        chk("final_mem_3ec", mem[251], 32'h44DEADBE);
`else
        chk("final_mem_3e8", mem[250], 32'h8877AB55);
        chk("final_mem_3ec", mem[251], 32'h12345678);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
